// File: rtl/accel_conditioner.sv
`default_nettype none
// accel_conditioner: learns a per-axis DC baseline, then emits rectified,
// gain-scaled, saturating 24-bit magnitudes for the CAV integrator.
module accel_conditioner #(
  parameter int          CAL_LOG2 = 8,
  parameter logic [15:0] GAIN     = 16'd64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sample_valid,
  input  logic [15:0] i_xdata_raw,
  input  logic [15:0] i_ydata_raw,
  input  logic [15:0] i_zdata_raw,
  input  logic        i_recal,
  output logic [23:0] o_xdata_scaled,
  output logic [23:0] o_ydata_scaled,
  output logic [23:0] o_zdata_scaled,
  output logic        o_valid,
  output logic        o_cal_done
);

  localparam int                ACC_W    = 16 + CAL_LOG2;
  localparam logic [CAL_LOG2:0] LAST_CNT = (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1);
  localparam logic [0:0]        ST_CAL   = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [CAL_LOG2:0] cnt;
  logic              cal_take;
  logic              cal_last;
  logic              run_take;
  logic              s1_valid;
  logic              out_valid;
  logic [15:0]       raw [3];

  assign raw[0] = i_xdata_raw;
  assign raw[1] = i_ydata_raw;
  assign raw[2] = i_zdata_raw;

  // A recal in the same cycle as a strobe discards the sample.
  assign cal_take = (state == ST_CAL) && i_sample_valid && !i_recal;
  assign cal_last = cal_take && (cnt == LAST_CNT);
  assign run_take = (state == ST_RUN) && i_sample_valid && !i_recal;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_CAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_recal) begin
      state_next = ST_CAL;
    end else if (cal_last) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    o_cal_done = (state == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_recal) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= run_take;
      out_valid <= s1_valid;
      if (cal_last) begin
        cnt <= '0;
      end else if (cal_take) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_valid = out_valid;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [15:0]      offset;
    logic [16:0]      diff;
    logic [16:0]      mag;
    logic [16:0]      mag_q;
    logic [32:0]      product;
    logic [23:0]      scaled_q;

    assign acc_sum = acc + {{CAL_LOG2{raw[a][15]}}, raw[a]};
    assign diff    = {raw[a][15], raw[a]} - {offset[15], offset};
    // -(-65536) wraps to 17'h10000, which reads correctly as unsigned 65536.
    assign mag     = diff[16] ? (~diff + 17'd1) : diff;
    assign product = {16'd0, mag_q} * {17'd0, GAIN};

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        acc      <= '0;
        offset   <= '0;
        mag_q    <= '0;
        scaled_q <= '0;
      end else if (i_recal) begin
        acc      <= '0;
        scaled_q <= '0;
      end else begin
        // Taking the upper bits of the full sum is the arithmetic-shift floor.
        if (cal_last) begin
          offset <= acc_sum[CAL_LOG2 +: 16];
          acc    <= '0;
        end else if (cal_take) begin
          acc <= acc_sum;
        end
        if (run_take) begin
          mag_q <= mag;
        end
        if (s1_valid) begin
          scaled_q <= (product > 33'h0_00FF_FFFF) ? 24'hFF_FFFF : product[23:0];
        end
      end
    end
  end

  assign o_xdata_scaled = g_axis[0].scaled_q;
  assign o_ydata_scaled = g_axis[1].scaled_q;
  assign o_zdata_scaled = g_axis[2].scaled_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_conditioner.sv
`default_nettype none
// tb_accel_conditioner: table vectors, corner sequences and randomized traffic
// checked against an arithmetic reference model (GAIN=64 and GAIN=16'hFFFF).
module tb_accel_conditioner;

  localparam int NCAL = 256;
  localparam longint SAT = 64'd16777215;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, sv, recal;
  logic signed [15:0] x, y, z;
  logic [23:0]        xa, ya, za, xb, yb, zb;
  logic               va, ca, vb, cb;

  accel_conditioner #(.CAL_LOG2(8), .GAIN(16'd64)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv),
    .i_xdata_raw(x), .i_ydata_raw(y), .i_zdata_raw(z), .i_recal(recal),
    .o_xdata_scaled(xa), .o_ydata_scaled(ya), .o_zdata_scaled(za),
    .o_valid(va), .o_cal_done(ca));

  accel_conditioner #(.CAL_LOG2(8), .GAIN(16'hFFFF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv),
    .i_xdata_raw(x), .i_ydata_raw(y), .i_zdata_raw(z), .i_recal(recal),
    .o_xdata_scaled(xb), .o_ydata_scaled(yb), .o_zdata_scaled(zb),
    .o_valid(vb), .o_cal_done(cb));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; longint v[2][3]; } pend_t;
  pend_t  pq[$];
  int     tcount = 0;
  bit     m_cal  = 1'b1;
  int     m_cnt  = 0;
  int     m_sum[3] = '{0, 0, 0};
  int     m_off[3] = '{0, 0, 0};
  longint exp_o[2][3] = '{'{0, 0, 0}, '{0, 0, 0}};
  bit     exp_v  = 1'b0;

  function automatic int floor_div(input int s);
    int q = s / NCAL;
    if (s < 0 && q * NCAL != s) q = q - 1;
    return q;
  endfunction

  function automatic longint cond(input int raw, input int off, input longint gain);
    longint a = longint'(raw) - longint'(off);
    longint p;
    if (a < 0) a = -a;
    p = a * gain;
    return (p > SAT) ? SAT : p;
  endfunction

  task automatic clear_outs();
    pq.delete();
    exp_v = 1'b0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) exp_o[d][k] = 0;
    m_cal = 1'b1;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) m_sum[k] = 0;
  endtask

  task automatic model_step();
    int r[3];
    pend_t p;
    tcount++;
    r[0] = int'(x); r[1] = int'(y); r[2] = int'(z);
    if (!rst_n) begin
      clear_outs();
      for (int k = 0; k < 3; k++) m_off[k] = 0;
      return;
    end
    if (recal) begin
      clear_outs();
      return;
    end
    exp_v = 1'b0;
    if (pq.size() > 0 && pq[0].due == tcount) begin
      p = pq.pop_front();
      exp_o = p.v;
      exp_v = 1'b1;
    end
    if (sv) begin
      if (m_cal) begin
        for (int k = 0; k < 3; k++) m_sum[k] += r[k];
        m_cnt++;
        if (m_cnt == NCAL) begin
          for (int k = 0; k < 3; k++) begin
            m_off[k] = floor_div(m_sum[k]);
            m_sum[k] = 0;
          end
          m_cnt = 0;
          m_cal = 1'b0;
        end
      end else begin
        p.due = tcount + 1;
        for (int k = 0; k < 3; k++) begin
          p.v[0][k] = cond(r[k], m_off[k], 64);
          p.v[1][k] = cond(r[k], m_off[k], 65535);
        end
        pq.push_back(p);
      end
    end
  endtask

  task automatic check_all();
    check($sformatf("c%0d va", tcount), va, exp_v);
    check($sformatf("c%0d vb", tcount), vb, exp_v);
    check($sformatf("c%0d ca", tcount), ca, !m_cal);
    check($sformatf("c%0d cb", tcount), cb, !m_cal);
    check($sformatf("c%0d xa", tcount), xa, exp_o[0][0]);
    check($sformatf("c%0d ya", tcount), ya, exp_o[0][1]);
    check($sformatf("c%0d za", tcount), za, exp_o[0][2]);
    check($sformatf("c%0d xb", tcount), xb, exp_o[1][0]);
    check($sformatf("c%0d yb", tcount), yb, exp_o[1][1]);
    check($sformatf("c%0d zb", tcount), zb, exp_o[1][2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input int xi, input int yi, input int zi);
    sv = v;
    x  = 16'(xi);
    y  = 16'(yi);
    z  = 16'(zi);
  endtask

  task automatic calibrate(input int n, input int xi, input int yi, input int zi);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, xi, yi, zi);
      tick();
    end
    drive(1'b0, 0, 0, 0);
  endtask

  typedef struct { bit v; int x, y, z; bit ev; int ex, ey, ez; } vec_t;
  vec_t tbl[9];

  initial begin
    logic [31:0] rv;
    tbl[0] = '{1, 150, -250, 16384, 0,    0,    0,  0};
    tbl[1] = '{0,   0,    0,     0, 1, 3200, 3200,  0};
    tbl[2] = '{1,  50, -200, 16384, 0, 3200, 3200,  0};
    tbl[3] = '{0,   0,    0,     0, 1, 3200,    0,  0};
    tbl[4] = '{1, 100, -200, 16384, 0, 3200,    0,  0};
    tbl[5] = '{1, 101, -199, 16383, 1,    0,    0,  0};
    tbl[6] = '{1,  99, -201, 16385, 1,   64,   64, 64};
    tbl[7] = '{0,   0,    0,     0, 1,   64,   64, 64};
    tbl[8] = '{0,   0,    0,     0, 0,   64,   64, 64};

    rst_n = 1'b0; recal = 1'b0;
    drive(1'b0, 0, 0, 0);
    tick(); tick();
    check("reset xa", xa, 0); check("reset va", va, 0); check("reset ca", ca, 0);
    rst_n = 1'b1;
    tick();

    // Calibration: done exactly one cycle after the 256th strobe, never o_valid.
    for (int i = 0; i < NCAL; i++) begin
      drive(1'b1, 100, -200, 16384);
      tick();
      check("cal no valid", va, 0);
      check("cal done timing", ca, (i == NCAL - 1) ? 1 : 0);
    end
    drive(1'b0, 0, 0, 0);
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].z);
      tick();
      check($sformatf("tbl%0d v", i), va, tbl[i].ev);
      check($sformatf("tbl%0d x", i), xa, tbl[i].ex);
      check($sformatf("tbl%0d y", i), ya, tbl[i].ey);
      check($sformatf("tbl%0d z", i), za, tbl[i].ez);
    end

    // Floor: mean -1.5 must round down to -2.
    recal = 1'b1; tick(); recal = 1'b0;
    check("recal clears done", ca, 0);
    for (int i = 0; i < NCAL; i++) begin
      drive(1'b1, (i % 2 == 0) ? -1 : -2, 0, 0);
      tick();
    end
    drive(1'b1, 0, 0, 0); tick();
    drive(1'b0, 0, 0, 0); tick();
    check("floor xa", xa, 128);
    check("floor xb", xb, 131070);

    // Extremes: offset -32768, sample 32767.
    recal = 1'b1; tick(); recal = 1'b0;
    calibrate(NCAL, -32768, 0, 0);
    drive(1'b1, 32767, 0, 0); tick();
    drive(1'b0, 0, 0, 0); tick();
    check("extreme xa", xa, 4194240);
    check("saturate xb", xb, SAT);
    check("extreme vb", vb, 1);

    // Recal collides with a strobe while another sample is in flight.
    drive(1'b1, 0, 0, 0); tick();
    recal = 1'b1; tick(); recal = 1'b0;
    check("collide va", va, 0);
    check("collide xa", xa, 0);
    check("collide ca", ca, 0);
    drive(1'b0, 0, 0, 0); tick();
    check("collide suppressed", va, 0);
    calibrate(NCAL - 1, 5, 5, 5);
    check("recal needs 256", ca, 0);
    calibrate(1, 5, 5, 5);
    check("recal done", ca, 1);

    // Reset mid-calibration restarts the count.
    recal = 1'b1; tick(); recal = 1'b0;
    calibrate(100, 7, 7, 7);
    rst_n = 1'b0;
    drive(1'b1, 7, 7, 7); tick(); tick();
    check("rst xa", xa, 0); check("rst va", va, 0); check("rst ca", ca, 0);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 0); tick();
    calibrate(NCAL - 1, 7, 7, 7);
    check("rst needs 256", ca, 0);
    calibrate(1, 7, 7, 7);
    check("rst done", ca, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rv    = $urandom;
      rst_n = ($urandom % 3000) != 0;
      recal = ($urandom % 1500) == 0;
      if (rv[31]) begin
        drive(rv[1:0] != 2'b00, int'($urandom_range(0, 400)) - 200,
              int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
      end else begin
        drive(rv[1:0] != 2'b00, int'($urandom % 65536) - 32768,
              int'($urandom % 65536) - 32768, int'($urandom % 65536) - 32768);
      end
      tick();
    end
    rst_n = 1'b1; recal = 1'b0;
    drive(1'b0, 0, 0, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
